ula: RTL and testbench
======================

Name: ula

Overview:
- Small registered arithmetic/logic unit (ULA) used as the datapath ALU slice of the MIPS core.
- Computes AND, OR and ADD of two operands in parallel and exposes all three as registered results.
- Also outputs a single selected result `z`, chosen by a 1-bit opcode.
- Default width is 1 bit; wider instances are built from the same block via `WIDTH`.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1 to 32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  1  result select: 0 = AND, 1 = OR.
- z  output  WIDTH  selected result, registered.
- y0  output  WIDTH  AND result (a & b), registered.
- y1  output  WIDTH  OR result (a | b), registered.
- y2  output  WIDTH  ADD result (a + b) truncated to WIDTH bits, registered.

Behaviour:
- Fully synchronous; every output is a flip-flop output. No combinational path from inputs to outputs.
- Reset:
  - On a rising clk edge with rst=1, z, y0, y1 and y2 all load 0.
  - Reset has priority over new operands.
  - rst=1 for N cycles holds all outputs at 0 for N cycles.
- Normal operation, on every rising clk edge with rst=0:
  - y0 <= a AND b (bitwise).
  - y1 <= a OR b (bitwise).
  - y2 <= (a + b) mod 2^WIDTH; the carry-out is discarded.
  - z <= (a AND b) when op=0; z <= (a OR b) when op=1.
- Latency:
  - Exactly 1 cycle: results reflect a/b/op sampled at the previous rising edge.
  - Throughput is one new operation per cycle; no handshake, no valid signal, no stall.
- z is computed from the current a/b/op, not from the registered y0/y1. Consequently z always equals y0 (when op was 0) or y1 (when op was 1) in the same cycle.
- Arithmetic:
  - Unsigned modular addition; no overflow flag.
  - WIDTH=1: y2 equals a XOR b.
  - All-ones + 1 wraps to 0.
- op changing with a/b unchanged: z switches on the next edge; y0/y1/y2 are unaffected.
- X or Z on inputs is not handled specially. The design must not infer latches.
- Reset asserted mid-stream: the operation sampled in that cycle is dropped. The first valid result appears one cycle after the first edge with rst=0.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1,b=1,op=1 -> z=y0=y1=y2=0 during reset; one edge after rst=0 -> z=1,y0=1,y1=1,y2=0.
- WIDTH=1, op=0, sweep (a,b) = (0,0),(0,1),(1,0),(1,1), one pair per cycle -> z = 0,0,0,1 one cycle later each; y1 = 0,1,1,1; y2 = 0,1,1,0.
- WIDTH=1, op=1, same sweep -> z = 0,1,1,1; y0 = 0,0,0,1.
- Op toggle with a=1,b=0 held, op 0->1->0 on consecutive cycles -> z = 0,1,0 with 1-cycle lag; y0=0, y1=1, y2=1 constant.
- WIDTH=8, a=8'hFF, b=8'h01, op=0 -> y0=8'h01, y1=8'hFF, y2=8'h00 (wrap), z=8'h01.
- Mid-stream reset, WIDTH=8: a=8'h0F,b=8'hF0,op=1 streaming; assert rst for 1 cycle -> outputs 0 that cycle, then z=y1=8'hFF, y0=8'h00, y2=8'hFF.

Source files
------------

// File: rtl/ula.sv
// Registered AND/OR/ADD slice with an op-selected result; one cycle latency,
// one operation per cycle, no flow control (never stalls).
module ula #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2
);

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] add_res;

  always_comb begin
    and_res = a & b;
    or_res  = a | b;
    add_res = a + b;
  end

  // z selects from the unregistered results so it lines up with y0/y1 in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
    end else begin
      z  <= op ? or_res : and_res;
      y0 <= and_res;
      y1 <= or_res;
      y2 <= add_res;
    end
  end

endmodule

// File: tb/tb_ula.sv
// Scoreboard bench for ula: drives a 1-bit and an 8-bit instance side by side
// and compares every registered output one edge after each stimulus.
module tb_ula;

  typedef struct {
    logic [7:0] z;
    logic [7:0] y0;
    logic [7:0] y1;
    logic [7:0] y2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [0:0] a1, b1;
  logic       op1;
  logic [0:0] z1, y0_1, y1_1, y2_1;
  logic [7:0] a8, b8;
  logic       op8;
  logic [7:0] z8, y0_8, y1_8, y2_8;

  int checks;
  int failures;

  exp_t q1[$];
  exp_t q8[$];

  ula #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .op(op1),
    .z(z1), .y0(y0_1), .y1(y1_1), .y2(y2_1)
  );

  ula #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .op(op8),
    .z(z8), .y0(y0_8), .y1(y1_8), .y2(y2_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic r, input logic [7:0] a, input logic [7:0] b,
                                 input logic op, input logic [7:0] mask);
    exp_t e;
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (r) begin
      e.z = 8'h00; e.y0 = 8'h00; e.y1 = 8'h00; e.y2 = 8'h00;
    end else begin
      e.y0 = (a & b) & mask;
      e.y1 = (a | b) & mask;
      e.y2 = sum[7:0] & mask;
      e.z  = op ? e.y1 : e.y0;
    end
    return e;
  endfunction

  // One operation on both instances: drive away from the edge, record the
  // expectation, then compare once the edge has registered it.
  task automatic step(input string tag, input logic r,
                      input logic a1v, input logic b1v, input logic op1v,
                      input logic [7:0] a8v, input logic [7:0] b8v, input logic op8v);
    exp_t e;
    @(negedge clk);
    rst = r;
    a1 = a1v; b1 = b1v; op1 = op1v;
    a8 = a8v; b8 = b8v; op8 = op8v;
    q1.push_back(model(r, {7'b0, a1v}, {7'b0, b1v}, op1v, 8'h01));
    q8.push_back(model(r, a8v, b8v, op8v, 8'hFF));
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q8.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q1.pop_front();
      check({tag, ".w1.z"},  {7'b0, z1},   e.z);
      check({tag, ".w1.y0"}, {7'b0, y0_1}, e.y0);
      check({tag, ".w1.y1"}, {7'b0, y1_1}, e.y1);
      check({tag, ".w1.y2"}, {7'b0, y2_1}, e.y2);
      e = q8.pop_front();
      check({tag, ".w8.z"},  z8,   e.z);
      check({tag, ".w8.y0"}, y0_8, e.y0);
      check({tag, ".w8.y1"}, y1_8, e.y1);
      check({tag, ".w8.y2"}, y2_8, e.y2);
    end
  endtask

  initial begin
    logic [1:0] ab;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; op1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; op8 = 1'b0;

    // Reset held two cycles with operands present, then release.
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    step("rel",  1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    // Spot checks against literal values for the first post-reset result.
    check("rel.lit.z1",  {7'b0, z1},   8'h01);
    check("rel.lit.y2_1", {7'b0, y2_1}, 8'h00);
    check("rel.lit.y2_8", y2_8,         8'h02);

    // 1-bit truth-table sweeps with both opcodes.
    for (int op = 0; op < 2; op++) begin
      for (int i = 0; i < 4; i++) begin
        ab = 2'(i);
        step($sformatf("sweep.op%0d.%0d", op, i), 1'b0, ab[1], ab[0], 1'(op),
             8'(i * 37), 8'(i * 91), 1'(op));
      end
    end

    // Opcode toggle with operands held.
    step("tog0", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0);
    step("tog1", 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1);
    check("tog1.lit.z1", {7'b0, z1}, 8'h01);
    step("tog2", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0);

    // Wrap-around addition.
    step("wrap", 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
    check("wrap.lit.y2", y2_8, 8'h00);
    check("wrap.lit.z",  z8,   8'h01);

    // Mid-stream reset drops the operation sampled under reset.
    step("mid0", 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 1'b1);
    step("mid1", 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 1'b1);
    check("mid1.lit.z", z8, 8'h00);
    step("mid2", 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 1'b1);
    check("mid2.lit.z",  z8,   8'hFF);
    check("mid2.lit.y0", y0_8, 8'h00);
    check("mid2.lit.y2", y2_8, 8'hFF);

    // Random back-to-back traffic with occasional reset.
    for (int i = 0; i < 60; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
